hazard_ctl: RTL and testbench

//  Pipeline hazard and sequencing controller for the 5-stage MIPS core.

---
 rtl/hazard_ctl_if.sv | 38 +++
 rtl/hazard_ctl.sv | 107 ++++++++++
 tb/tb_hazard_ctl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_if.sv
// Hazard controller bus: ID/EX hazard inputs and the pipeline stall/flush,
// mult/div sequencing and performance-counter outputs.
interface hazard_ctl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        Rs_ID;
    logic [4:0]        Rt_ID;
    logic [4:0]        WriteReg_EX;
    logic              RegWrite_EX;
    logic              MemToReg_EX;
    logic              BranchTaken_EX;
    logic              MulDivStart_ID;
    logic              HiLoRead_ID;
    logic              Stall_IF;
    logic              Stall_ID;
    logic              Flush_ID;
    logic              Flush_EX;
    logic              MulDivGo;
    logic              MulDivBusy;
    logic              MulDivDone;
    logic [PERF_W-1:0] StallCnt;

    // Pipeline side: supplies hazard information, consumes controls
    modport master (
        output Rs_ID, Rt_ID, WriteReg_EX, RegWrite_EX, MemToReg_EX,
               BranchTaken_EX, MulDivStart_ID, HiLoRead_ID,
        input  Stall_IF, Stall_ID, Flush_ID, Flush_EX,
               MulDivGo, MulDivBusy, MulDivDone, StallCnt
    );

    // Controller side
    modport slave (
        input  Rs_ID, Rt_ID, WriteReg_EX, RegWrite_EX, MemToReg_EX,
               BranchTaken_EX, MulDivStart_ID, HiLoRead_ID,
        output Stall_IF, Stall_ID, Flush_ID, Flush_EX,
               MulDivGo, MulDivBusy, MulDivDone, StallCnt
    );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline hazard and sequencing controller for the 5-stage MIPS core.
// Load-use detection, branch flush, mult/div HI/LO sequencing and a
// saturating stall-cycle counter. Every output is forced low during reset.
module hazard_ctl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6,
    parameter int PERF_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctl_if.slave hif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  next_count;
    logic [PERF_W-1:0] stall_cnt;
    logic              load_use;
    logic              hilo_haz;
    logic              hold;
    logic              go;
    logic              busy;
    logic              done;

    // Hazard detection: load-use and HI/LO-busy hazards; a taken branch wins
    always_comb begin
        load_use = hif.MemToReg_EX && hif.RegWrite_EX && (hif.WriteReg_EX != 5'd0)
                   && ((hif.WriteReg_EX == hif.Rs_ID) || (hif.WriteReg_EX == hif.Rt_ID));
        hilo_haz = (state == BUSY) && (hif.HiLoRead_ID || hif.MulDivStart_ID);
        hold     = (load_use || hilo_haz) && !hif.BranchTaken_EX;
    end

    // Mult/div sequencer state and down-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Mult/div sequencer next state; DONE may restart directly for back-to-back ops
    always_comb begin
        next_state = state;
        next_count = count;
        go         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (hif.MulDivStart_ID && !hold && !hif.BranchTaken_EX) begin
                    go         = 1'b1;
                    next_state = BUSY;
                    next_count = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count == '0) begin
                    next_state = DONE;
                end else begin
                    next_count = count - 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (hif.MulDivStart_ID && !hold && !hif.BranchTaken_EX) begin
                    go         = 1'b1;
                    next_state = BUSY;
                    next_count = CNT_W'(MULDIV_CYCLES - 1);
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Saturating count of cycles in which decode was held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hold && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Output drive, gated so that everything reads zero while reset is high
    always_comb begin
        hif.Stall_IF   = hold && !reset;
        hif.Stall_ID   = hold && !reset;
        hif.Flush_EX   = (hold || hif.BranchTaken_EX) && !reset;
        hif.Flush_ID   = hif.BranchTaken_EX && !reset;
        hif.MulDivGo   = go && !reset;
        hif.MulDivBusy = busy && !reset;
        hif.MulDivDone = done && !reset;
        hif.StallCnt   = stall_cnt;
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed testbench for hazard_ctl with MULDIV_CYCLES=4 and PERF_W=4.
module tb_hazard_ctl;

    localparam int MC = 4;
    localparam int PW = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    hazard_ctl_if #(.PERF_W(PW)) bus ();

    hazard_ctl #(
        .MULDIV_CYCLES(MC),
        .CNT_W        (6),
        .PERF_W       (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs on the falling edge, then settle before checking
    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] wr, input logic regwrite,
                                  input logic memtoreg, input logic branch,
                                  input logic start, input logic hiloread);
        @(negedge clk);
        bus.Rs_ID          = rs;
        bus.Rt_ID          = rt;
        bus.WriteReg_EX    = wr;
        bus.RegWrite_EX    = regwrite;
        bus.MemToReg_EX    = memtoreg;
        bus.BranchTaken_EX = branch;
        bus.MulDivStart_ID = start;
        bus.HiLoRead_ID    = hiloread;
        #1;
    endtask

    // One comparison of an observed value against its expected value
    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pack the control outputs as {Stall_IF,Stall_ID,Flush_ID,Flush_EX,Go,Busy,Done}
    function automatic logic [15:0] ctl();
        return {9'd0, bus.Stall_IF, bus.Stall_ID, bus.Flush_ID, bus.Flush_EX,
                bus.MulDivGo, bus.MulDivBusy, bus.MulDivDone};
    endfunction

    // Directed test sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.Rs_ID          = 5'd0;
        bus.Rt_ID          = 5'd0;
        bus.WriteReg_EX    = 5'd0;
        bus.RegWrite_EX    = 1'b0;
        bus.MemToReg_EX    = 1'b0;
        bus.BranchTaken_EX = 1'b0;
        bus.MulDivStart_ID = 1'b0;
        bus.HiLoRead_ID    = 1'b0;

        // Outputs held at zero during reset despite hazard-causing inputs
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("reset_loaduse", ctl(), 16'h0000);
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_output("reset_branch", ctl(), 16'h0000);
        check_output("reset_cnt", 16'(bus.StallCnt), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use on Rs: stall IF/ID and bubble EX
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("lu_rs", ctl(), 16'b1101000);
        // Destination $zero never hazards
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("lu_zero", ctl(), 16'h0000);
        check_output("lu_cnt1", 16'(bus.StallCnt), 16'd1);
        // Load-use on Rt
        apply_stimulus(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("lu_rt", ctl(), 16'b1101000);
        // Not a load: no stall
        apply_stimulus(5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("lu_noload", ctl(), 16'h0000);
        // Branch overrides load-use
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("branch_ovr", ctl(), 16'b0011000);
        check_output("branch_cnt", 16'(bus.StallCnt), 16'd2);

        // Clear the counter before the mult/div sequence
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("reset2_cnt", 16'(bus.StallCnt), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mult/div: Go at t0, Busy t1..t4 with mfhi stalled, Done at t5
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("md_go", ctl(), 16'b0000100);
        for (int i = 1; i <= MC; i++) begin
            apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_output($sformatf("md_busy_t%0d", i), ctl(), 16'b1101010);
        end
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("md_done", ctl(), 16'b0000001);
        check_output("md_cnt4", 16'(bus.StallCnt), 16'd4);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("md_idle", ctl(), 16'h0000);

        // Back-to-back: second mult waits through BUSY, issues in DONE
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("b2b_go1", ctl(), 16'b0000100);
        for (int i = 1; i <= MC; i++) begin
            apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("b2b_wait_t%0d", i), ctl(), 16'b1101010);
        end
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("b2b_done_go", ctl(), 16'b0000101);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b2b_busy", ctl(), 16'b0000010);
        check_output("b2b_cnt8", 16'(bus.StallCnt), 16'd8);
        // Taken branch during BUSY flushes but does not abort the op
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_output("busy_branch", ctl(), 16'b0011010);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("busy_after_br", ctl(), 16'b0000010);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("busy_last", ctl(), 16'b0000010);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("b2b_done2", ctl(), 16'b0000001);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("idle2", ctl(), 16'h0000);

        // Reset asserted mid-op at count 2 drops outputs asynchronously
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("rst_go", ctl(), 16'b0000100);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("rst_pre", ctl(), 16'b1101010);
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_async", ctl(), 16'h0000);
        check_output("rst_async_cnt", 16'(bus.StallCnt), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("rst_mfhi_free", ctl(), 16'h0000);
        for (int i = 0; i < MC + 1; i++) begin
            apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_output($sformatf("rst_idle_%0d", i), ctl(), 16'h0000);
        end

        // Saturation: 20 stall cycles, counter holds at 15
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("sat_%0d", i), 16'(bus.StallCnt),
                         16'((i - 1) > 15 ? 15 : (i - 1)));
        end
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("sat_final", 16'(bus.StallCnt), 16'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
